// File: rtl/sdram_resp_model.sv
// sdram_resp_model: SDR SDRAM device responder with per-bank rows, mode register and burst engine.
// Define SDRAM_RESP_CHECK_EN to enable the protocol checker (err_pulse / err_code).
module sdram_resp_model #(
    parameter int DW             = 32,
    parameter int COL_BITS       = 8,
    parameter int ROW_STORE_BITS = 4
) (
    input  logic                sdram_clk,
    input  logic                sdram_resetn,
    input  logic                sdr_cs_n,
    input  logic                sdr_ras_n,
    input  logic                sdr_cas_n,
    input  logic                sdr_we_n,
    input  logic [1:0]          sdr_ba,
    input  logic [12:0]         sdr_addr,
    input  logic [DW/8-1:0]     sdr_dqm,
    input  logic [DW-1:0]       sdr_dq_i,
    output logic [DW-1:0]       sdr_dq_o,
    output logic                sdr_dq_oe,
    output logic                err_pulse,
    output logic [2:0]          err_code
);
    localparam int DEPTH = 4 << (ROW_STORE_BITS + COL_BITS);
    localparam int AW    = 2 + ROW_STORE_BITS + COL_BITS;

    typedef enum logic [1:0] {B_IDLE, B_WR, B_RD} bst_t;

    bst_t                      r_state, w_state_nx;
    logic [DW-1:0]             r_mem [0:DEPTH-1];
    logic [3:0]                r_bank_act;
    logic [ROW_STORE_BITS-1:0] r_bank_row [4];
    logic [1:0]                r_bl_log;
    logic                      r_cl3;
    logic [1:0]                r_bst_ba, r_bst_bl;
    logic [ROW_STORE_BITS-1:0] r_bst_row;
    logic [COL_BITS-1:0]       r_bst_col;
    logic [2:0]                r_bst_k;
    logic                      r_bst_cl3, r_bst_ap;
    logic                      r_p1_v, r_p2_v, r_dq_oe;
    logic [DW-1:0]             r_p1_d, r_p2_d, r_dq_o;

    logic [3:0]                w_cmd;
    logic                      w_act, w_rd, w_wr, w_pre, w_ref, w_lmr, w_bst;
    logic                      w_bank_open, w_new, w_kill, w_beat, w_last, w_flush, w_rd_beat;
    logic                      w_b_wr, w_b_cl3, w_b_ap;
    logic [1:0]                w_b_ba, w_b_bl;
    logic [ROW_STORE_BITS-1:0] w_b_row;
    logic [COL_BITS-1:0]       w_b_col0, w_mask, w_col;
    logic [2:0]                w_b_k;
    logic [AW-1:0]             w_idx;
    logic [DW-1:0]             w_rd_d;
    logic [1:0]                w_lmr_bl;
    logic                      w_lmr_cl3;
    logic                      w_unused;

    assign w_cmd       = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};
    assign w_act       = w_cmd == 4'b0011;
    assign w_rd        = w_cmd == 4'b0101;
    assign w_wr        = w_cmd == 4'b0100;
    assign w_pre       = w_cmd == 4'b0010;
    assign w_ref       = w_cmd == 4'b0001;
    assign w_lmr       = w_cmd == 4'b0000;
    assign w_bst       = w_cmd == 4'b0110;
    assign w_unused    = ^sdr_addr;
    assign w_bank_open = r_bank_act[sdr_ba];
    assign w_new       = (w_rd || w_wr) && w_bank_open;
    assign w_kill      = w_bst || (w_pre && (sdr_addr[10] || sdr_ba == r_bst_ba));
    assign w_beat      = w_new || (r_state != B_IDLE && !w_kill);
    assign w_flush     = w_new && w_wr;
    // Unsupported BL codes fall back to BL8, unsupported CL to CL3
    assign w_lmr_bl    = sdr_addr[2] ? 2'd3 : sdr_addr[1:0];
    assign w_lmr_cl3   = sdr_addr[6:4] != 3'd2;

    always_comb begin
        w_b_wr     = w_new ? w_wr : r_state == B_WR;
        w_b_ba     = w_new ? sdr_ba : r_bst_ba;
        w_b_row    = w_new ? r_bank_row[sdr_ba] : r_bst_row;
        w_b_col0   = w_new ? sdr_addr[COL_BITS-1:0] : r_bst_col;
        w_b_k      = w_new ? 3'd0 : r_bst_k;
        w_b_bl     = w_new ? r_bl_log : r_bst_bl;
        w_b_cl3    = w_new ? r_cl3 : r_bst_cl3;
        w_b_ap     = w_new ? sdr_addr[10] : r_bst_ap;
        w_mask     = COL_BITS'((4'd1 << w_b_bl) - 4'd1);
        w_col      = (w_b_col0 & ~w_mask) | ((w_b_col0 + COL_BITS'(w_b_k)) & w_mask);
        w_idx      = {w_b_ba, w_b_row, w_col};
        w_last     = w_b_k == w_mask[2:0];
        w_rd_beat  = w_beat && !w_b_wr;
        w_rd_d     = w_rd_beat ? r_mem[w_idx] : '0;
        w_state_nx = (w_beat && !w_last) ? (w_b_wr ? B_WR : B_RD) : B_IDLE;
    end

    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn) begin
            r_state    <= B_IDLE;
            r_bank_act <= '0;
            r_bl_log   <= 2'd0;
            r_cl3      <= 1'b0;
            r_bst_ba   <= '0;
            r_p1_v     <= 1'b0;
            r_p2_v     <= 1'b0;
            r_p1_d     <= '0;
            r_p2_d     <= '0;
            r_dq_oe    <= 1'b0;
            r_dq_o     <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_beat) begin
                r_bst_ba  <= w_b_ba;
                r_bst_row <= w_b_row;
                r_bst_col <= w_b_col0;
                r_bst_bl  <= w_b_bl;
                r_bst_cl3 <= w_b_cl3;
                r_bst_ap  <= w_b_ap;
                r_bst_k   <= w_b_k + 3'd1;
            end
            if (w_beat && w_last && w_b_ap)
                r_bank_act[w_b_ba] <= 1'b0;
            if (w_act) begin
                r_bank_act[sdr_ba] <= 1'b1;
                r_bank_row[sdr_ba] <= sdr_addr[ROW_STORE_BITS-1:0];
            end
            if (w_pre && sdr_addr[10])
                r_bank_act <= '0;
            else if (w_pre)
                r_bank_act[sdr_ba] <= 1'b0;
            if (w_lmr) begin
                r_bl_log <= w_lmr_bl;
                r_cl3    <= w_lmr_cl3;
            end
            // Beats carry their own CL: CL3 takes one extra stage through p2
            r_p2_v  <= w_rd_beat && w_b_cl3;
            r_p2_d  <= w_b_cl3 ? w_rd_d : '0;
            r_p1_v  <= w_flush ? 1'b0 : (w_rd_beat && !w_b_cl3) ? 1'b1 : r_p2_v;
            r_p1_d  <= w_flush ? '0 : (w_rd_beat && !w_b_cl3) ? w_rd_d : r_p2_d;
            r_dq_oe <= !w_flush && r_p1_v;
            r_dq_o  <= w_flush ? '0 : r_p1_d;
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_resetn && w_beat && w_b_wr)
            for (int b = 0; b < DW / 8; b++)
                if (!sdr_dqm[b])
                    r_mem[w_idx][8*b +: 8] <= sdr_dq_i[8*b +: 8];
    end

    assign sdr_dq_o  = r_dq_o;
    assign sdr_dq_oe = r_dq_oe;

`ifdef SDRAM_RESP_CHECK_EN
    logic [2:0] w_err, r_err_code;
    logic       r_err_pulse;

    assign w_err = ((w_rd || w_wr) && !w_bank_open)          ? 3'd1 :
                   (w_act && w_bank_open)                    ? 3'd2 :
                   ((w_ref || w_lmr) && |r_bank_act)         ? 3'd3 :
                   (w_lmr && (sdr_addr[2] || sdr_addr[6:5] != 2'b01)) ? 3'd4 : 3'd0;

    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn) begin
            r_err_pulse <= 1'b0;
            r_err_code  <= 3'd0;
        end else begin
            r_err_pulse <= |w_err;
            if (|w_err)
                r_err_code <= w_err;
        end
    end

    assign err_pulse = r_err_pulse;
    assign err_code  = r_err_code;
`else
    assign err_pulse = 1'b0;
    assign err_code  = 3'd0;
`endif
endmodule

// File: doc/sdram_resp_model.md
# sdram_resp_model

Synthesizable SDRAM device responder: the memory-side end of the SDR SDRAM command bus driven by the SDRAM controller under test. It decodes CS/RAS/CAS/WE commands, tracks per-bank open rows, honours the loaded mode register (CAS latency, burst length) and serves read/write bursts from an internal word array. It sits in the top-level test harness in place of an external SDRAM part, with an optional protocol checker that flags illegal command sequences.

## Interface
- DW, 32: SDRAM data width (8, 16 or 32).
- COL_BITS, 8: column address bits used (sdr_addr[COL_BITS-1:0]).
- ROW_STORE_BITS, 4: low row bits backed by storage; upper row bits alias.
- sdram_clk  in  1  single clock; all inputs sampled and outputs updated on rising edge.
- sdram_resetn  in  1  synchronous, active-low reset.
- sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n  in  1 each  command lines.
- sdr_ba  in  2  bank address.
- sdr_addr  in  13  row / column / mode address; A10 = auto-precharge / all-banks.
- sdr_dqm  in  DW/8  write byte mask (1 = byte not written).
- sdr_dq_i  in  DW  write data.
- sdr_dq_o  out  DW  read data.
- sdr_dq_oe  out  1  read data valid / drive enable.
- err_pulse  out  1  one-cycle protocol error strobe.
- err_code  out  3  code of most recent error (sticky until next error or reset).

## Operation
- Commands ({cs_n,ras_n,cas_n,we_n}): 1xxx/0111 NOP; 0011 ACTIVE; 0101 READ; 0100 WRITE; 0010 PRECHARGE; 0001 AUTO REFRESH; 0000 LOAD MODE; 0110 BURST TERMINATE.
- Per-bank state: IDLE or ACTIVE(row). ACTIVE opens row sdr_addr; PRECHARGE closes sdr_ba, or all banks when A10=1.
- Mode register: BL = A[2:0] (000=1, 001=2, 010=4, 011=8); CL = A[6:4] (2 or 3). Only sequential bursts.
- Storage index {ba, row[ROW_STORE_BITS-1:0], col}; 4·2^ROW_STORE_BITS·2^COL_BITS words; contents not reset.
- Burst engine states: IDLE, WR_BURST, RD_BURST. READ/WRITE loads bank, row, start column, beat counter = BL.
- Column sequence wraps inside the BL-aligned block: col = {start[COL_BITS-1:log2BL], (start[log2BL-1:0]+k) mod BL}.
- WRITE: beat k data sdr_dq_i written at edge n+k (command at edge n), byte lanes masked by sdr_dqm of that cycle.
- READ: beat k read at edge n+k, pushed into a CL-deep pipeline.
- New READ/WRITE terminates current burst and starts the new one; BURST TERMINATE or PRECHARGE of the burst bank ends it with no further beats.
- WRITE issued during a read flushes undelivered read beats (dq_oe low from next cycle).
- A10=1 on READ/WRITE: bank closes after the last beat.

## Timing
- Reset (sdram_resetn low at an edge): all banks IDLE, mode = CL2/BL1, burst IDLE, read pipeline empty, sdr_dq_o=0, sdr_dq_oe=0, err_pulse=0, err_code=0. Reset mid-burst aborts with no further beats.
- Read latency: READ sampled at edge n; beat k registered on edge n+CL+k-1, so the controller samples it at edge n+CL+k.
- sdr_dq_oe high exactly for delivered beats; sdr_dq_o = 0 when dq_oe low.
- Write latency 0: data accompanies the command cycle.
- LOAD MODE takes effect for commands at edge n+1; in-flight beats keep their CL/BL.
- Back-to-back READs (n, n+1) with BL=1 yield consecutive beats with no gap.

## Configuration
- SDRAM_RESP_CHECK_EN defined: checker active; on violation err_pulse=1 for one cycle (at edge after the offending command) and err_code updated:
  - 1 READ/WRITE to IDLE bank (access ignored);
  - 2 ACTIVE to ACTIVE bank (row replaced);
  - 3 AUTO REFRESH or LOAD MODE with any bank ACTIVE (command still executed);
  - 4 unsupported mode (BL 100–111 → BL8, CL ≠ 2/3 → CL3).
- Not defined: no checking logic; err_pulse and err_code tied to 0; illegal sequences behave as above silently.

## Test plan
- Reset then LOAD MODE 0x032 (CL3, BL4); ACTIVE ba1 row 5; WRITE col 0x10 data 0xA0..0xA3; READ col 0x10 -> dq_oe high at edges n+3..n+6, data 0xA0,0xA1,0xA2,0xA3.
- BL4 READ at col 0x12 -> data order cols 0x12,0x13,0x10,0x11 (wrap).
- WRITE 0xDEADBEEF with dqm=4'b0101 over 0x11111111 -> read returns 0xDE11BE11.
- CL2 BL8 READ, BURST TERMINATE at n+2 -> exactly 2 beats delivered, dq_oe low after.
- With SDRAM_RESP_CHECK_EN: READ to closed bank 2 -> err_pulse one cycle, err_code=1, dq_oe stays 0; then ACTIVE twice on bank 0 -> err_code=2.
- sdram_resetn low during CL3 read pipeline -> dq_oe=0 next edge, mode back to CL2/BL1, all banks IDLE.
